// File: rtl/knn_pkg.sv
// Shared KNN accelerator definitions: sequencer state encoding and default widths.
package knn_pkg;

  localparam int KNN_NUM_DIM = 32;
  localparam int KNN_DATA_W  = 32;
  localparam int KNN_IDX_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    LOAD   = 2'd2,
    STREAM = 2'd3
  } knn_state_e;

endpackage

// File: rtl/knn_dim_counter.sv
// Mirror of the query fifo's internal word counter. Wraps at NUM_DIMENSIONS-1
// and also clears on the falling edge of load, exactly like the fifo does.
module knn_dim_counter #(
  parameter int NUM_DIMENSIONS = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_load,
  output logic [$clog2(NUM_DIMENSIONS)-1:0] o_cnt,
  output logic                              o_load_fall
);

  localparam int CW = $clog2(NUM_DIMENSIONS);

  logic [CW-1:0] r_cnt;
  logic          r_load_d;

  assign o_cnt       = r_cnt;
  assign o_load_fall = r_load_d & ~i_load;

  // Free-running phase counter with wrap and load-fall clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_load_d <= 1'b0;
    end else begin
      r_load_d <= i_load;
      if (r_cnt == CW'(NUM_DIMENSIONS-1) || o_load_fall) r_cnt <= '0;
      else                                               r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/knn_query_sequencer.sv
// Sequences query-vector load into the non-stallable fifo, then streams
// training vectors in lockstep with the fifo's output word.
module knn_query_sequencer
  import knn_pkg::*;
#(
  parameter int NUM_DIMENSIONS = KNN_NUM_DIM,
  parameter int DATA_WIDTH     = KNN_DATA_W,
  parameter int IDX_WIDTH      = KNN_IDX_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [IDX_WIDTH-1:0]  i_num_train,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_t_valid,
  output logic                  o_t_ready,
  input  logic [DATA_WIDTH-1:0] i_t_data,
  output logic                  o_fifo_load,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  output logic                  o_op_valid,
  output logic [DATA_WIDTH-1:0] o_op_train,
  output logic                  o_op_first,
  output logic                  o_op_last,
  output logic [IDX_WIDTH-1:0]  o_op_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int CW = $clog2(NUM_DIMENSIONS);

  knn_state_e           r_state, w_state_nxt;
  logic [CW-1:0]        r_lcnt;
  logic [CW-1:0]        r_tb;
  logic [IDX_WIDTH-1:0] r_ntrain;
  logic [IDX_WIDTH-1:0] r_idx;
  logic                 r_err;
  logic                 r_done;

  logic [CW-1:0]        w_mcnt;
  logic                 w_load_fall;
  logic                 w_s_ready;
  logic                 w_t_ready;
  logic                 w_load;
  logic                 w_op_valid;
  logic                 w_tb_last;
  logic                 w_idx_last;
  logic                 w_gap;

  assign w_load     = i_s_valid & w_s_ready;
  assign w_op_valid = i_t_valid & w_t_ready;
  assign w_tb_last  = (r_tb == CW'(NUM_DIMENSIONS-1));
  assign w_idx_last = (r_idx == r_ntrain - 1'b1);
  assign w_gap      = (r_tb != '0) & ~i_t_valid;

  knn_dim_counter #(.NUM_DIMENSIONS(NUM_DIMENSIONS)) u_mcnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_load),
    .o_cnt       (w_mcnt),
    .o_load_fall (w_load_fall)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and handshake readies
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_t_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && i_num_train != '0) w_state_nxt = ALIGN;
      end
      ALIGN: begin
        w_s_ready = (w_mcnt == '0);
        if (w_load) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_s_ready = 1'b1;
        if (!i_s_valid)                         w_state_nxt = IDLE;
        else if (r_lcnt == CW'(NUM_DIMENSIONS-1)) w_state_nxt = STREAM;
      end
      STREAM: begin
        // A vector starts only on a phase-0 cycle that advances to phase 1.
        // The first zero after the load (load-fall cycle) repeats phase 0, so
        // a vector started there would pair beat 1 with mem[0].
        w_t_ready = (r_tb != '0) || (w_mcnt == '0 && !w_load_fall);
        if (w_gap)                                  w_state_nxt = IDLE;
        else if (w_op_valid && w_tb_last && w_idx_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job bookkeeping: beat counters, vector index, done pulse, sticky error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lcnt   <= '0;
      r_tb     <= '0;
      r_ntrain <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_err    <= 1'b0;
            r_ntrain <= i_num_train;
            r_idx    <= '0;
            r_done   <= (i_num_train == '0);
          end
        end
        ALIGN: begin
          if (w_load) r_lcnt <= CW'(1);
        end
        LOAD: begin
          r_tb <= '0;
          if (!i_s_valid) r_err  <= 1'b1;
          else            r_lcnt <= r_lcnt + 1'b1;
        end
        STREAM: begin
          if (w_gap) begin
            r_err <= 1'b1;
            r_tb  <= '0;
          end else if (w_op_valid) begin
            if (w_tb_last) begin
              r_tb  <= '0;
              r_idx <= r_idx + 1'b1;
              if (w_idx_last) r_done <= 1'b1;
            end else begin
              r_tb <= r_tb + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_s_ready   = w_s_ready;
  assign o_t_ready   = w_t_ready;
  assign o_fifo_load = w_load;
  assign o_fifo_data = w_load ? i_s_data : '0;
  assign o_op_valid  = w_op_valid;
  assign o_op_train  = w_op_valid ? i_t_data : '0;
  assign o_op_first  = w_op_valid & (r_tb == '0);
  assign o_op_last   = w_op_valid & w_tb_last;
  assign o_op_idx    = r_idx;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
